// File: rtl/cross_bar_slave_arbiter.sv
// Per-slave-port arbiter for the cross bar.
// Masters whose address decodes to SLAVE_ID compete round-robin. The winner's
// address, command and write data are latched and presented to the slave
// until it accepts, or until the timeout fires. Reads take one extra
// response cycle that passes s_rdata back to the owner.
module cross_bar_slave_arbiter #(
    parameter int         NUM_MASTERS = 4,
    parameter int         AW          = 32,
    parameter int         DW          = 32,
    parameter logic [1:0] SLAVE_ID    = 2'd0,
    parameter int         TIMEOUT     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    m_req,
    input  logic [NUM_MASTERS*AW-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]    m_cmd,
    input  logic [NUM_MASTERS*DW-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic [NUM_MASTERS-1:0]    m_rvalid,
    output logic [NUM_MASTERS-1:0]    m_err,
    output logic [DW-1:0]             m_rdata,
    output logic                      s_req,
    output logic [AW-1:0]             s_addr,
    output logic                      s_cmd,
    output logic [DW-1:0]             s_wdata,
    input  logic                      s_ack,
    input  logic [DW-1:0]             s_rdata,
    output logic [NUM_MASTERS-1:0]    grant
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic                   cmd_q, cmd_d;
    logic [DW-1:0]          wdata_q, wdata_d;

    logic [NUM_MASTERS-1:0] eligible;
    logic                   win_found;
    logic [PW-1:0]          win_idx;
    logic [PW:0]            cand;
    logic                   timer_done;

    // A master competes only when it requests and its address targets this slave
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_elig
        assign eligible[gi] = m_req[gi] && (m_addr[gi*AW + AW - 1 -: 2] == SLAVE_ID);
    end

    assign timer_done = (timer_q == TW'(TIMEOUT - 1));

    // Round-robin search: first eligible index starting at rr_ptr, wrapping around
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_MASTERS)) begin
                cand = cand - (PW+1)'(NUM_MASTERS);
            end
            if (!win_found && eligible[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    // State register and latched transaction copy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            timer_q  <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            cmd_q    <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            timer_q  <= timer_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            cmd_q    <= cmd_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for ack or timeout in BUSY
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        timer_d  = timer_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        cmd_d    = cmd_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d  = NUM_MASTERS'(1) << win_idx;
                    addr_d   = m_addr[win_idx*AW +: AW];
                    cmd_d    = m_cmd[win_idx];
                    wdata_d  = m_wdata[win_idx*DW +: DW];
                    rr_ptr_d = (win_idx == PW'(NUM_MASTERS - 1)) ? '0 : win_idx + PW'(1);
                    timer_d  = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (s_ack) begin
                    // ack wins over a timeout landing in the same cycle
                    if (cmd_q) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = RESP;
                    end
                end else if (timer_done) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output decode; reset forces every master- and slave-facing strobe low
    always_comb begin
        m_ack    = '0;
        m_rvalid = '0;
        m_err    = '0;
        m_rdata  = '0;
        s_req    = 1'b0;
        grant    = '0;
        if (!rst) begin
            grant = grant_q;
            case (state_q)
                BUSY: begin
                    s_req = 1'b1;
                    if (s_ack) begin
                        m_ack = grant_q;
                    end else if (timer_done) begin
                        m_err = grant_q;
                    end
                end
                RESP: begin
                    m_rvalid = grant_q;
                    m_rdata  = s_rdata;
                end
                default: ;
            endcase
        end
    end

    assign s_addr  = addr_q;
    assign s_cmd   = cmd_q;
    assign s_wdata = wdata_q;

endmodule

// File: tb/tb_cross_bar_slave_arbiter.sv
// Randomized scoreboard bench for cross_bar_slave_arbiter (SLAVE_ID=1).
// The driver picks the expected winner from the round-robin rule and pushes
// the responses it expects; a negedge monitor pops and compares them.
module tb_cross_bar_slave_arbiter;

    localparam int NM  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 16;
    localparam logic [1:0] SID = 2'd1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NM-1:0]      m_req;
    logic [NM*AW-1:0]   m_addr;
    logic [NM-1:0]      m_cmd;
    logic [NM*DW-1:0]   m_wdata;
    logic [NM-1:0]      m_ack, m_rvalid, m_err, grant;
    logic [DW-1:0]      m_rdata;
    logic               s_req, s_cmd;
    logic [AW-1:0]      s_addr;
    logic [DW-1:0]      s_wdata;
    logic               s_ack = 1'b0;
    logic [DW-1:0]      s_rdata = '0;

    logic          tb_req   [NM];
    logic [AW-1:0] tb_addr  [NM];
    logic          tb_cmd   [NM];
    logic [DW-1:0] tb_wdata [NM];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            m_req[i]             = tb_req[i];
            m_cmd[i]             = tb_cmd[i];
            m_addr[i*AW +: AW]   = tb_addr[i];
            m_wdata[i*DW +: DW]  = tb_wdata[i];
        end
    end

    cross_bar_slave_arbiter #(
        .NUM_MASTERS(NM), .AW(AW), .DW(DW), .SLAVE_ID(SID), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rvalid(m_rvalid), .m_err(m_err), .m_rdata(m_rdata),
        .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata), .grant(grant)
    );

    // kind: 0 = ack, 1 = read data, 2 = timeout error
    typedef struct {
        int            kind;
        logic [NM-1:0] vec;
        logic [AW-1:0] addr;
        logic          cmd;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rr     = 0;
    int   busy_cnt = 0;
    int   txn_no = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest expected response
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            int   kind;
            logic [NM-1:0] vec;
            if (s_req) busy_cnt++; else busy_cnt = 0;
            check("strobe_onehot", 64'($countones({m_ack, m_rvalid, m_err}) <= 1), 64'd1);
            if (m_rvalid == '0) check("rdata_idle_zero", 64'(m_rdata), 64'd0);
            if ((m_ack | m_rvalid | m_err) != '0) begin
                kind = (m_ack != '0) ? 0 : ((m_rvalid != '0) ? 1 : 2);
                vec  = (kind == 0) ? m_ack : ((kind == 1) ? m_rvalid : m_err);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 64'(kind), 64'd99);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_kind", 64'(kind), 64'(e.kind));
                    check("resp_vec", 64'(vec), 64'(e.vec));
                    if (e.kind == 1) begin
                        check("m_rdata", 64'(m_rdata), 64'(e.rdata));
                    end else begin
                        check("s_addr", 64'(s_addr), 64'(e.addr));
                        check("s_cmd", 64'(s_cmd), 64'(e.cmd));
                        check("s_wdata", 64'(s_wdata), 64'(e.wdata));
                        check("grant_at_resp", 64'(grant), 64'(e.vec));
                        check("busy_cycles", 64'(busy_cnt), 64'(e.cyc));
                    end
                end
            end
        end
    end

    // One arbitration round. Called at #1 after a posedge while the DUT is IDLE,
    // with the request arrays already holding this round's stimulus.
    task automatic run_txn(input int delay, input logic [DW-1:0] rd, input bit poke);
        int   w = -1;
        exp_t e;
        for (int k = 0; k < NM; k++) begin
            int idx = (rr + k) % NM;
            if (w < 0 && tb_req[idx] && tb_addr[idx][AW-1:AW-2] == SID) w = idx;
        end
        txn_no++;
        if (w < 0) begin
            $display("txn %0d: no eligible request", txn_no);
            @(posedge clk); #1;
            check("idle_s_req", 64'(s_req), 64'd0);
            check("idle_grant", 64'(grant), 64'd0);
            return;
        end
        rr = (w + 1) % NM;
        e.vec   = NM'(1) << w;
        e.addr  = tb_addr[w];
        e.cmd   = tb_cmd[w];
        e.wdata = tb_wdata[w];
        e.rdata = '0;
        if (delay < TO) begin
            e.kind = 0; e.cyc = delay + 1;
            exp_q.push_back(e);
            if (!tb_cmd[w]) begin
                e.kind = 1; e.rdata = rd;
                exp_q.push_back(e);
            end
        end else begin
            e.kind = 2; e.cyc = TO;
            exp_q.push_back(e);
        end
        $display("txn %0d: master %0d %s addr=%h delay=%0d", txn_no, w,
                 tb_cmd[w] ? "write" : "read", tb_addr[w], delay);
        @(posedge clk); #1;
        check("s_req_latency", 64'(s_req), 64'd1);
        check("grant_owner", 64'(grant), 64'(e.vec));
        if (poke) begin
            tb_addr[w]  = tb_addr[w] ^ 32'h0000_0F0F;
            tb_wdata[w] = ~tb_wdata[w];
            tb_cmd[w]   = ~tb_cmd[w];
        end
        for (int k = 0; ; k++) begin
            s_ack   = (k == delay);
            s_rdata = $urandom;
            @(posedge clk); #1;
            if (k == delay || k == TO - 1) break;
        end
        s_ack = 1'b0;
        if (delay < TO && !e.cmd) begin
            s_rdata = rd;
            @(posedge clk); #1;
        end
        s_rdata = $urandom;
    endtask

    task automatic set_m(input int i, input logic rq, input logic [AW-1:0] a,
                         input logic c, input logic [DW-1:0] d);
        tb_req[i] = rq; tb_addr[i] = a; tb_cmd[i] = c; tb_wdata[i] = d;
    endtask

    initial begin
        for (int i = 0; i < NM; i++) set_m(i, 1'b1, 32'h4000_0100 + 32'(i), 1'b1, 32'(i + 16));

        // reset held two cycles with every master requesting
        repeat (2) begin
            @(negedge clk);
            check("rst_s_req", 64'(s_req), 64'd0);
            check("rst_grant", 64'(grant), 64'd0);
            check("rst_strobes", 64'({m_ack, m_rvalid, m_err}), 64'd0);
            check("rst_rdata", 64'(m_rdata), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(0, '0, 1'b0);                      // first grant: master 0

        // single write by master 2, acked on the 2nd BUSY cycle
        for (int i = 0; i < NM; i++) tb_req[i] = 1'b0;
        set_m(2, 1'b1, 32'h4000_0010, 1'b1, 32'd5);
        run_txn(1, '0, 1'b0);

        // read by master 1
        tb_req[2] = 1'b0;
        set_m(1, 1'b1, 32'h4000_0020, 1'b0, 32'd0);
        run_txn(0, 32'hDEAD_BEEF, 1'b0);

        // round robin with all four holding requests, immediate ack
        for (int i = 0; i < NM; i++) set_m(i, 1'b1, 32'h4000_0200 + 32'(i), 1'b1, 32'(i));
        rr = rr;                                   // model pointer carries over
        repeat (5) run_txn(0, '0, 1'b0);

        // address filter + latching: master 0 targets slave 2, master 3 slave 1
        for (int i = 0; i < NM; i++) tb_req[i] = 1'b0;
        set_m(0, 1'b1, 32'h8000_0000, 1'b1, 32'h1111_1111);
        set_m(3, 1'b1, 32'h4000_0030, 1'b1, 32'h3333_3333);
        run_txn(2, '0, 1'b1);
        tb_req[3] = 1'b0;
        run_txn(0, '0, 1'b0);                      // only slave-2 request left

        // timeout, then a normal transaction afterwards
        tb_req[0] = 1'b0;
        set_m(2, 1'b1, 32'h4000_0040, 1'b1, 32'h2222_2222);
        run_txn(100, '0, 1'b0);
        tb_req[2] = 1'b0;
        set_m(1, 1'b1, 32'h4000_0050, 1'b0, 32'd0);
        run_txn(3, 32'h1234_5678, 1'b0);

        // randomized rounds
        repeat (60) begin
            for (int i = 0; i < NM; i++) begin
                logic [AW-1:0] a;
                a = $urandom;
                a[AW-1:AW-2] = ($urandom_range(0, 1) == 1) ? SID : 2'($urandom_range(0, 3));
                set_m(i, 1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), $urandom);
            end
            run_txn(($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 5)),
                    $urandom, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < NM; i++) tb_req[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cross_bar_slave_arbiter.md
Name: cross_bar_slave_arbiter

Overview:
- One instance per cross_bar slave port.
- Arbitrates among NUM_MASTERS masters whose request address decodes to this slave (addr[AW-1:AW-2] == SLAVE_ID).
- Issues one transaction at a time to the slave and routes ack, read data and timeout error back to the winning master.
- Round-robin fairness; the grant is held until the transaction completes.

Parameters:
- NUM_MASTERS, 4, number of requesting masters.
- AW, 32, address width; top 2 bits select the slave.
- DW, 32, data width.
- SLAVE_ID, 0, 2-bit slave index this instance serves.
- TIMEOUT, 16, maximum BUSY cycles to wait for s_ack; must be >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- m_req  in  NUM_MASTERS  per-master request.
- m_addr  in  NUM_MASTERS*AW  packed addresses; master i at [i*AW +: AW].
- m_cmd  in  NUM_MASTERS  1=write, 0=read.
- m_wdata  in  NUM_MASTERS*DW  packed write data.
- m_ack  out  NUM_MASTERS  one-hot accept pulse to the granted master.
- m_rvalid  out  NUM_MASTERS  one-hot read-data-valid pulse.
- m_err  out  NUM_MASTERS  one-hot timeout error pulse.
- m_rdata  out  DW  read data, shared by all masters.
- s_req  out  1  request to slave.
- s_addr  out  AW  latched address.
- s_cmd  out  1  latched command.
- s_wdata  out  DW  latched write data.
- s_ack  in  1  slave accept.
- s_rdata  in  DW  slave read data, valid the cycle after s_ack for reads.
- grant  out  NUM_MASTERS  one-hot current owner; 0 in IDLE.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, rr_ptr=0, timer=0, grant=0, latched addr/cmd/wdata=0.
- Outputs during and after reset: m_ack=0, m_rvalid=0, m_err=0, m_rdata=0, s_req=0.
- Reset mid-transaction drops the transaction silently; no ack or err is issued.
- eligible[i] = m_req[i] && m_addr[i][AW-1:AW-2] == SLAVE_ID.
- IDLE:
  - If eligible != 0, pick the first eligible index searching rr_ptr, rr_ptr+1, ... mod NUM_MASTERS.
  - Register grant, addr, cmd and wdata from the winner; set rr_ptr = winner+1 mod NUM_MASTERS; timer=0; go to BUSY.
  - No eligible request: stay in IDLE.
- BUSY:
  - s_req=1; s_addr, s_cmd, s_wdata come from the latched copy, so master-side changes after the grant have no effect.
  - s_ack=1: m_ack = grant, combinational in the same cycle. Write goes to IDLE; read goes to RESP.
  - s_ack=0: timer increments. When timer == TIMEOUT-1 with no ack, m_err = grant for one cycle and state goes to IDLE.
  - s_ack has priority over timeout in the same cycle.
- RESP (one cycle):
  - s_req=0; m_rvalid = grant; m_rdata = s_rdata, combinational pass-through.
  - Then go to IDLE and clear grant.
- m_rdata is 0 whenever m_rvalid = 0.
- Latency from request seen in IDLE:
  - s_req asserts on the next cycle.
  - Minimum write is 3 cycles until the next arbitration (IDLE, BUSY, IDLE).
  - Minimum read is 4 cycles.
- The winning master must drop or change m_req after its m_ack. If it does not, it re-arbitrates at lowest priority.
- Requests to other slaves are ignored.
- Exactly one bit of m_ack/m_rvalid/m_err may be set in any cycle.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all m_req=1 → s_req=0, grant=0, all m_* outputs 0. First grant after release goes to master 0.
- Single write: SLAVE_ID=1; master 2 issues req with addr=0x4000_0010, cmd=1, wdata=5; slave acks on the 2nd BUSY cycle → s_addr=0x4000_0010, s_wdata=5, m_ack=4'b0100 for one cycle, back to IDLE, m_rvalid never set.
- Read: master 1 reads; slave acks, then s_rdata=0xDEAD_BEEF next cycle → m_ack=4'b0010, then m_rvalid=4'b0010 with m_rdata=0xDEAD_BEEF on the following cycle.
- Round robin: all four masters hold continuous requests to this slave, each acked immediately → grant order 0,1,2,3,0. The order must not be 0,0,...
- Address filter and latching: master 0 targets slave 2 and master 3 targets slave 1 (SLAVE_ID=1) → only master 3 granted. Master 3 changes wdata during BUSY → s_wdata keeps the latched value.
- Timeout: TIMEOUT=16, slave never acks → m_err=grant exactly 16 cycles after s_req first rises, no m_ack. Next arbitration proceeds normally.
